// File: rtl/lcd_state_sequencer.sv
// lcd_state_sequencer: turns single-cycle game events into LCD display codes
// and owns message timing (transient dwell, end-of-game begin/end stepping).
// Latency: an event sampled at edge N is visible on state/busy after edge N.
// Backpressure: none; events arriving while a dwell runs are dropped, except
// exploded during a transient dwell, which is remembered until expiry.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   auth_ok/fail    credential result pulses
//   level_ok/fail   level result pulses, qualified by level (1..3, 0 invalid)
//   defused         bomb defused pulse
//   exploded        bomb timer expired pulse
//   state           display code to the LCD controller
//   busy            a dwell timer is running
module lcd_state_sequencer #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int SEQ_CYCLES  = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       auth_ok,
   input  logic       auth_fail,
   input  logic       level_ok,
   input  logic       level_fail,
   input  logic       defused,
   input  logic       exploded,
   input  logic [1:0] level,
   output logic [7:0] state,
   output logic       busy
);

   typedef enum logic [7:0] {
      S_AUTH      = 8'h00,
      S_AUTH_OK   = 8'h01,
      S_AUTH_FAIL = 8'h02,
      S_GAME      = 8'h10,
      S_L1_OK     = 8'h11,
      S_L1_FAIL   = 8'h12,
      S_L2_OK     = 8'h13,
      S_L2_FAIL   = 8'h14,
      S_L3_FAIL   = 8'h16,
      S_WIN       = 8'h20,
      S_WIN_END   = 8'h21,
      S_LOSE      = 8'h30,
      S_LOSE_END  = 8'h31
   } state_t;

   // Counter values at which the next edge ends the dwell.
   localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);
   localparam logic [26:0] SEQ_LAST  = 27'(SEQ_CYCLES - 1);

   state_t      cur;
   state_t      nxt;
   state_t      hold_tgt;
   logic        chg;
   logic        in_hold;
   logic [26:0] cnt;
   logic        pend_x;
   logic        busy_r;

   wire hold_done = (cnt == HOLD_LAST);
   wire seq_done  = (cnt == SEQ_LAST);
   wire lvl_valid = (level != 2'd0);

   // Codes that run a dwell timer (transient and sequence classes).
   function automatic logic is_timed(input state_t s);
      case (s)
         S_AUTH, S_GAME, S_WIN_END, S_LOSE_END: is_timed = 1'b0;
         default:                               is_timed = 1'b1;
      endcase
   endfunction

   always_comb begin
      nxt      = cur;
      chg      = 1'b0;
      in_hold  = 1'b0;
      hold_tgt = S_GAME;
      case (cur)
         S_AUTH: begin
            if (auth_fail) begin
               nxt = S_AUTH_FAIL;
               chg = 1'b1;
            end else if (auth_ok) begin
               nxt = S_AUTH_OK;
               chg = 1'b1;
            end
         end
         S_GAME: begin
            if (exploded) begin
               nxt = S_LOSE;
               chg = 1'b1;
            end else if (defused) begin
               nxt = S_WIN;
               chg = 1'b1;
            end else if (level_fail && lvl_valid) begin
               chg = 1'b1;
               case (level)
                  2'd1:    nxt = S_L1_FAIL;
                  2'd2:    nxt = S_L2_FAIL;
                  default: nxt = S_L3_FAIL;
               endcase
            end else if (level_ok && lvl_valid) begin
               chg = 1'b1;
               case (level)
                  2'd1:    nxt = S_L1_OK;
                  2'd2:    nxt = S_L2_OK;
                  default: nxt = S_WIN;
               endcase
            end
         end
         S_AUTH_OK, S_L1_OK, S_L2_OK: begin
            in_hold  = 1'b1;
            hold_tgt = S_GAME;
         end
         S_AUTH_FAIL: begin
            in_hold  = 1'b1;
            hold_tgt = S_AUTH;
         end
         S_L1_FAIL, S_L2_FAIL, S_L3_FAIL: begin
            in_hold  = 1'b1;
            hold_tgt = S_LOSE;
         end
         S_WIN: begin
            if (seq_done) begin
               nxt = S_WIN_END;
               chg = 1'b1;
            end
         end
         S_LOSE: begin
            if (seq_done) begin
               nxt = S_LOSE_END;
               chg = 1'b1;
            end
         end
         S_WIN_END, S_LOSE_END: begin
            // Terminal: only reset leaves.
         end
         default: begin
            nxt = S_AUTH;
            chg = 1'b1;
         end
      endcase

      // A remembered explosion (or one arriving on the final dwell cycle)
      // overrides the normal auto-advance target.
      if (in_hold && hold_done) begin
         nxt = (pend_x || exploded) ? S_LOSE : hold_tgt;
         chg = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur    <= S_AUTH;
         cnt    <= '0;
         pend_x <= 1'b0;
         busy_r <= 1'b0;
      end else if (chg) begin
         cur    <= nxt;
         cnt    <= '0;
         pend_x <= 1'b0;
         busy_r <= is_timed(nxt);
      end else begin
         if (busy_r) cnt <= cnt + 27'd1;
         if (in_hold && exploded) pend_x <= 1'b1;
      end
   end

   assign state = cur;
   assign busy  = busy_r;

endmodule

// File: doc/lcd_state_sequencer.md
# lcd_state_sequencer

Produces the 8-bit display-state code consumed by the LCD controller, turning single-cycle game events from the authentication and level logic into the controller's message codes. It owns all message timing: transient messages are held for a fixed dwell, then auto-advanced. The end-of-game begin/end sequences are stepped on a timer. The block sits directly upstream of the LCD controller; `state` connects straight to the controller's `state` input.

## Interface
- HOLD_CYCLES, 25_000_000, dwell of a transient message (0.5 s at 50 MHz); must be ≥2 and <2^27
- SEQ_CYCLES, 50_000_000, dwell of 0x20 and 0x30 before stepping to 0x21/0x31; must be ≥2 and <2^27

- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- auth_ok  in  1  single-cycle pulse: credentials accepted
- auth_fail  in  1  single-cycle pulse: credentials rejected
- level_ok  in  1  single-cycle pulse: current level solved
- level_fail  in  1  single-cycle pulse: current level failed
- defused  in  1  single-cycle pulse: bomb defused
- exploded  in  1  single-cycle pulse: bomb timer expired
- level  in  2  current level, 1..3; 0 is invalid
- state  out  8  display code to the LCD controller
- busy  out  1  high while a dwell timer is running

## Operation
**Display codes**
- 0x00 auth pending
- 0x01 auth ok; 0x02 auth fail
- 0x10 game in progress
- 0x11 L1 ok; 0x12 L1 fail; 0x13 L2 ok; 0x14 L2 fail; 0x16 L3 fail
- 0x20/0x21 success begin/end
- 0x30/0x31 game-over begin/end

**Code classes**
- Stable: 0x00, 0x10. No timer runs; `busy`=0.
- Transient: 0x01, 0x02, 0x11–0x16. The timer runs for HOLD_CYCLES; `busy`=1.
- Sequence: 0x20, 0x30. The timer runs for SEQ_CYCLES; `busy`=1.
- Terminal: 0x21, 0x31. Left only by reset; `busy`=0.

**Accepted events (all others are ignored)**
- In 0x00:
  - auth_ok → 0x01
  - auth_fail → 0x02
- In 0x10:
  - exploded → 0x30
  - defused → 0x20
  - level_fail → 0x12/0x14/0x16 for level 1/2/3
  - level_ok → 0x11/0x13 for level 1/2, or 0x20 for level 3
  - A level event with level=0 is ignored.
- Same-cycle priority: exploded > defused > level_fail > level_ok > auth_fail > auth_ok. Only the winning event acts.

**Dwell expiry (auto-advance)**
- 0x01 → 0x10
- 0x02 → 0x00
- 0x11, 0x13 → 0x10
- 0x12, 0x14, 0x16 → 0x30
- 0x20 → 0x21
- 0x30 → 0x31

**Pending explosion**
- During a transient dwell, an `exploded` pulse sets `pend_x`.
- At expiry, if `pend_x`=1 the next code is 0x30, overriding the auto-advance target. `pend_x` clears on that transition.
- All other events during any dwell are dropped.
- `exploded` during 0x20, 0x30 or a terminal code is ignored.

## Timing
- Reset (reset=0 at an edge):
  - state=0x00, busy=0, counter=0, pend_x=0.
  - Reset dominates all events in the same cycle, including mid-dwell.
- Event latency:
  - A pulse sampled at edge N makes the new code visible after edge N.
  - `busy` rises on the same edge as the new code.
- Dwell counter:
  - 27-bit; cleared on every code change; increments each cycle while busy.
  - When counter = DWELL−1 (DWELL = HOLD_CYCLES or SEQ_CYCLES), the next edge changes the code.
  - A code entered at edge N therefore changes at edge N+DWELL.
- Dwell chaining:
  - On expiry into another timed code, `busy` stays 1 with no gap and the counter restarts at 0.
  - On expiry into 0x00 or 0x10, `busy` drops on the expiry edge.
  - The first event is accepted on the following edge.
- `state` changes only at code transitions; it never glitches between them.

## Test plan
- Reset, then auth_fail pulse → state 0x02 next cycle; after HOLD_CYCLES, 0x00 with busy=0. Use HOLD_CYCLES=8 and SEQ_CYCLES=16 for sim.
- auth_ok, then level_ok at level=1, then level_ok at level=3:
  - auth_ok → 0x01, then 0x10 after 8 cycles.
  - level_ok, level=1 → 0x11, then 0x10.
  - level_ok, level=3 → 0x20, then 0x21 after 16 cycles.
  - 0x21 holds through 100 further event pulses.
- In 0x10, drive level_fail at level=2 → 0x14 for 8 cycles, then 0x30, then 0x31 after 16 cycles. busy=1 continuously over those 24 cycles.
- Simultaneous pulses in 0x10 → winner by priority:
  - level_ok+level_fail → 0x12 (level=1).
  - defused+exploded → 0x30.
  - level_ok with level=0 → stays 0x10.
- In 0x11, exploded at dwell cycle 3 → at expiry, 0x30 instead of 0x10. auth_ok during the dwell has no effect.
- In 0x30 at dwell cycle 5, assert reset → 0x00, busy=0 on the next edge. A following auth_ok → 0x01.
